// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file and its clear sequencer.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
// Contents: clear-FSM state type, clog2-safe address width helper, default
// XLEN/DEPTH shared with decode and writeback.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int DEPTH_DEF = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // Keeps the address at least one bit wide even for degenerate depths.
  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Bulk-clear sequencer: walks every register index once, one per cycle.
// Latency: busy rises the edge after clrReq, stays high exactly DEPTH cycles.
// Backpressure: clrReq is ignored while a sequence is running; no stall input.
// Ports: clk, rstN (async active-low), clrReq (pulse), busy, clrWe/clrAddr
// (per-cycle zero-write strobe and index toward the storage array).
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          clrReq,
  output logic          busy,
  output logic          clrWe,
  output logic [AW-1:0] clrAddr
);

  clr_state_t    state_q;
  clr_state_t    state_d;
  logic [AW-1:0] cnt_q;
  logic          last_idx;

  assign last_idx = (cnt_q == AW'(DEPTH - 1));

  // State register and index counter.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && clrReq) begin
        cnt_q <= '0;
      end else if (state_q == CLEAR) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Next-state logic: a request while already clearing does not restart.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clrReq)   state_d = CLEAR;
      CLEAR:   if (last_idx) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend on registered state only, so clrReq never reaches busy
  // combinationally.
  always_comb begin
    busy    = (state_q == CLEAR);
    clrWe   = (state_q == CLEAR);
    clrAddr = cnt_q;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional hardwired zero register and
// sequenced bulk clear. Latency: reads combinational, writes visible next cycle
// (same cycle with WR_BYPASS_EN). Backpressure: writes dropped while busy.
// Ports: clk, rstN (async active-low); wrEn/rd/dIn packed write ports (port 1
// wins on address conflict); rs/rOut packed read ports; clrReq pulse, busy.
// Build option: define WR_BYPASS_EN to forward same-cycle write data to reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int DEPTH    = DEPTH_DEF,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WR   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = addr_w(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic [NUM_WR-1:0]      wrEn,
  input  logic [NUM_WR*AW-1:0]   rd,
  input  logic [NUM_WR*XLEN-1:0] dIn,
  input  logic [NUM_RD*AW-1:0]   rs,
  output logic [NUM_RD*XLEN-1:0] rOut,
  input  logic                   clrReq,
  output logic                   busy
);

  logic            clr_we;
  logic [AW-1:0]   clr_addr;

  logic [XLEN-1:0] mem    [DEPTH];
  logic [AW-1:0]   wa     [NUM_WR];
  logic [XLEN-1:0] wd     [NUM_WR];
  logic [NUM_WR-1:0] wr_ok;
  logic [AW-1:0]   ra     [NUM_RD];
  logic [XLEN-1:0] rd_val [NUM_RD];

  regfile_clr_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_seq (
    .clk     (clk),
    .rstN    (rstN),
    .clrReq  (clrReq),
    .busy    (busy),
    .clrWe   (clr_we),
    .clrAddr (clr_addr)
  );

  // A write is live only when idle, in range, and not aimed at the zero register.
  always_comb begin
    wa    = '{default: '0};
    wd    = '{default: '0};
    wr_ok = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      wa[w]    = rd[w*AW +: AW];
      wd[w]    = dIn[w*XLEN +: XLEN];
      wr_ok[w] = wrEn[w] && !busy && (int'(wa[w]) < DEPTH) &&
                 !((ZERO_REG != 0) && (wa[w] == '0));
    end
  end

  // Ports applied in ascending order so the highest port wins a conflict.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_ok[w]) begin
          mem[wa[w]] <= wd[w];
        end
      end
    end
  end

  always_comb begin
    ra     = '{default: '0};
    rd_val = '{default: '0};
    for (int r = 0; r < NUM_RD; r++) begin
      ra[r] = rs[r*AW +: AW];
      if ((int'(ra[r]) < DEPTH) && !((ZERO_REG != 0) && (ra[r] == '0))) begin
        rd_val[r] = mem[ra[r]];
      end
`ifdef WR_BYPASS_EN
      // wr_ok already excludes busy and the zero register.
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_ok[w] && (wa[w] == ra[r])) begin
          rd_val[r] = wd[w];
        end
      end
`endif
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    assign rOut[g*XLEN +: XLEN] = rd_val[g];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (DEPTH 32, two read and two write ports).
// Stimulus pushes expected read data and busy per cycle; a negedge monitor
// pops and compares against the DUT.
module tb_regfile_mp;

  logic        clk_tb;
  logic        rst_n;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_dat;
  logic [9:0]  rd_addr;
  logic [63:0] rd_dat;
  logic        clr_req;
  logic        busy;
  logic        chk_vld;

  typedef struct {
    logic [31:0] r0;
    logic [31:0] r1;
    logic        b;
    int          tag;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_chk;
  int          n_err;
  int          tag_n;

  // Reference model: plain array plus the index of the next entry to clear
  // (-1 when no clear is running).
  logic [31:0] ref_mem [32];
  int          clr_pos;

  regfile_mp #(
    .XLEN     (32),
    .DEPTH    (32),
    .NUM_RD   (2),
    .NUM_WR   (2),
    .ZERO_REG (1)
  ) dut (
    .clk    (clk_tb),
    .rstN   (rst_n),
    .wrEn   (wr_en),
    .rd     (wr_addr),
    .dIn    (wr_dat),
    .rs     (rd_addr),
    .rOut   (rd_dat),
    .clrReq (clr_req),
    .busy   (busy)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  function automatic logic [31:0] ref_read(input int a, input bit we0, input int a0,
                                           input logic [31:0] d0, input bit we1,
                                           input int a1, input logic [31:0] d1);
    logic [31:0] res;
    res = (a == 0) ? 32'h0 : ref_mem[a];
`ifdef WR_BYPASS_EN
    if (clr_pos < 0 && a != 0) begin
      if (we0 && a0 == a) res = d0;
      if (we1 && a1 == a) res = d1;
    end
`else
    if (we0 && we1 && a0 == a1 && a0 < 0) res = d0 ^ d1;  // never true
`endif
    return res;
  endfunction

  // One clock cycle: drive inputs, queue expectations, advance the model.
  task automatic cycle(input bit we0, input int a0, input logic [31:0] d0,
                       input bit we1, input int a1, input logic [31:0] d1,
                       input int r0, input int r1, input bit clr);
    exp_t e;
    @(posedge clk_tb);
    #1;
    wr_en   = {we1, we0};
    wr_addr = {5'(a1), 5'(a0)};
    wr_dat  = {d1, d0};
    rd_addr = {5'(r1), 5'(r0)};
    clr_req = clr;
    e.r0  = ref_read(r0, we0, a0, d0, we1, a1, d1);
    e.r1  = ref_read(r1, we0, a0, d0, we1, a1, d1);
    e.b   = (clr_pos >= 0);
    e.tag = tag_n;
    tag_n++;
    exp_q.push_back(e);
    chk_vld = 1'b1;
    if (clr_pos >= 0) begin
      ref_mem[clr_pos] = 32'h0;
      clr_pos++;
      if (clr_pos == 32) clr_pos = -1;
    end else begin
      if (we0 && a0 != 0) ref_mem[a0] = d0;
      if (we1 && a1 != 0) ref_mem[a1] = d1;
      if (clr) clr_pos = 0;
    end
  endtask

  task automatic rd_only(input int r0, input int r1);
    cycle(0, 0, 32'h0, 0, 0, 32'h0, r0, r1, 0);
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) rd_only(2*i, 2*i + 1);
  endtask

  // Asserts reset mid-cycle and checks the asynchronous effect before release.
  task automatic async_reset(input int r0, input int r1);
    exp_t e;
    @(posedge clk_tb);
    #1;
    rst_n   = 1'b0;
    wr_en   = '0;
    clr_req = 1'b0;
    rd_addr = {5'(r1), 5'(r0)};
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    clr_pos = -1;
    e.r0  = 32'h0;
    e.r1  = 32'h0;
    e.b   = 1'b0;
    e.tag = tag_n;
    tag_n++;
    exp_q.push_back(e);
    chk_vld = 1'b1;
    @(negedge clk_tb);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk_tb) begin
    if (chk_vld) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL scoreboard_empty: DUT output sampled with no expectation queued");
      end else begin
        mon_e = exp_q.pop_front();
        n_chk++;
        if (rd_dat[31:0] !== mon_e.r0) begin
          n_err++;
          $display("FAIL rout0 #%0d: got %h want %h", mon_e.tag, rd_dat[31:0], mon_e.r0);
        end
        n_chk++;
        if (rd_dat[63:32] !== mon_e.r1) begin
          n_err++;
          $display("FAIL rout1 #%0d: got %h want %h", mon_e.tag, rd_dat[63:32], mon_e.r1);
        end
        n_chk++;
        if (busy !== mon_e.b) begin
          n_err++;
          $display("FAIL busy #%0d: got %b want %b", mon_e.tag, busy, mon_e.b);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk   = 0;
    n_err   = 0;
    tag_n   = 0;
    clr_pos = -1;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    chk_vld = 1'b0;
    wr_en   = '0;
    wr_addr = '0;
    wr_dat  = '0;
    rd_addr = '0;
    clr_req = 1'b0;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;

    // Reset state: every register reads zero.
    read_all();

    // Basic write then pairwise read-back.
    for (int i = 1; i < 32; i++)
      cycle(1, i, 32'hFAFAFA00 + 32'(i), 0, 0, 32'h0, i, i - 1, 0);
    for (int i = 1; i < 32; i++) rd_only(i, (i + 1) % 32);

    // Zero register ignores writes.
    cycle(1, 0, 32'hDEADBEEF, 0, 0, 32'h0, 0, 1, 0);
    rd_only(0, 0);

    // Same-address dual write: port 1 wins.
    cycle(1, 5, 32'h11111111, 1, 5, 32'h22222222, 5, 6, 0);
    rd_only(5, 6);

    // Same-cycle read of the address being written (forwarded only with bypass).
    cycle(1, 9, 32'hCAFEF00D, 0, 0, 32'h0, 9, 8, 0);
    rd_only(9, 8);

    // Randomised traffic on both write ports.
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom), int'($urandom_range(31)), $urandom,
            1'($urandom), int'($urandom_range(31)), $urandom,
            int'($urandom_range(31)), int'($urandom_range(31)), 0);

    // Bulk clear: fill, request with a same-cycle write, probe during the walk.
    for (int i = 0; i < 32; i++)
      cycle(1, i, $urandom, 0, 0, 32'h0, i, 31 - i, 0);
    cycle(1, 4, 32'h44444444, 0, 0, 32'h0, 3, 20, 1);
    for (int k = 0; k < 34; k++) begin
      if (k == 10)
        cycle(1, 7, 32'h77777777, 1, 21, 32'h21212121, 7, 21, 0);
      else if (k == 15)
        cycle(0, 0, 32'h0, 0, 0, 32'h0, 3, 20, 1);
      else if (k < 8)
        cycle(0, 0, 32'h0, 0, 0, 32'h0, 4, k, 0);
      else
        cycle(0, 0, 32'h0, 0, 0, 32'h0, 3, 20, 0);
    end
    read_all();

    // Reset in the middle of a clear, then a fresh clear from index 0.
    for (int i = 0; i < 32; i++)
      cycle(1, i, $urandom, 0, 0, 32'h0, 0, 0, 0);
    cycle(0, 0, 32'h0, 0, 0, 32'h0, 12, 25, 1);
    for (int k = 0; k < 10; k++) rd_only(k, 25);
    async_reset(25, 30);
    read_all();
    for (int i = 0; i < 32; i++)
      cycle(1, i, 32'hA5000000 + 32'(i), 0, 0, 32'h0, 0, 0, 0);
    cycle(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 1);
    for (int k = 0; k < 34; k++) rd_only(k % 32, 31 - (k % 32));
    read_all();

    @(posedge clk_tb);
    #1;
    chk_vld = 1'b0;
    @(negedge clk_tb);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
